// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART TX core between NUM_REQ clients.
// Optional macro UART_ARB_PRIO0_EN gives requester 0 fixed priority over the rotation.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4,
  parameter int TO_W    = 3
) (
  input  logic                      clk,
  input  logic                      rest,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_par_en,
  input  logic [NUM_REQ-1:0]        req_par_typ,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_par_en,
  output logic                      tx_par_typ,
  output logic                      tx_data_valid,
  input  logic                      tx_busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic [TO_W-1:0]   cnt;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Search starts just after the previous winner and wraps modulo NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] cand;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (req_valid[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state         <= IDLE;
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
      tx_data       <= '0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= 1'b0;
      grant_id      <= '0;
      last_grant    <= ID_W'(NUM_REQ - 1);
      cnt           <= '0;
    end else begin
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && found) begin
            tx_data           <= data_arr[winner];
            tx_par_en         <= req_par_en[winner];
            tx_par_typ        <= req_par_typ[winner];
            grant_id          <= winner;
            req_ready[winner] <= 1'b1;
`ifdef UART_ARB_PRIO0_EN
            // A priority grant must not disturb the rotation among the others.
            if (winner != '0) last_grant <= winner;
`else
            last_grant <= winner;
`endif
            state <= START;
          end
        end
        START: begin
          tx_data_valid <= 1'b1;
          cnt           <= '0;
          state         <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          // Frame length depends on baud rate and parity, so no timeout here.
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, timeout, busy blocking, mid-frame reset, fairness.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rest;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic [3:0]  req_par_typ;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic [7:0]  tx_data;
  logic        tx_par_en;
  logic        tx_par_typ;
  logic        tx_data_valid;
  logic        tx_busy;
  logic        timeout_err;

  int passed = 0;
  int total  = 0;

  logic [7:0] fdata [4];
  logic [3:0] pen_pat;
  logic [3:0] ptyp_pat;

  uart_tx_arbiter dut (
    .clk(clk), .rest(rest), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ), .req_ready(req_ready),
    .grant_id(grant_id), .tx_data(tx_data), .tx_par_en(tx_par_en),
    .tx_par_typ(tx_par_typ), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_valid"}, 32'(tx_data_valid), 32'h0);
    check({tag, "_terr"},  32'(timeout_err), 32'h0);
    check({tag, "_data"},  32'(tx_data), 32'h0);
    check({tag, "_gid"},   32'(grant_id), 32'h0);
    check({tag, "_pen"},   32'(tx_par_en), 32'h0);
    check({tag, "_ptyp"},  32'(tx_par_typ), 32'h0);
  endtask

  // One full frame with the core going busy one cycle after launch for 10 cycles.
  task automatic frame(input int g);
    int n = 0;
    int extra = 0;
    while (req_ready == 4'b0 && n < 20) begin
      step();
      n++;
    end
    check("frm_ready", 32'(req_ready), 32'(1 << g));
    check("frm_gid",   32'(grant_id), 32'(g));
    check("frm_data",  32'(tx_data), 32'(fdata[g]));
    step();
    check("frm_launch", 32'(tx_data_valid), 32'h1);
    check("frm_pen",    32'(tx_par_en), 32'(pen_pat[g]));
    check("frm_ptyp",   32'(tx_par_typ), 32'(ptyp_pat[g]));
    tx_busy = 1'b1;
    repeat (10) begin
      step();
      if (tx_data_valid) extra++;
    end
    tx_busy = 1'b0;
    check("frm_one_pulse", 32'(extra), 32'h0);
  endtask

  initial begin
    fdata       = '{8'h11, 8'h22, 8'h33, 8'h44};
    pen_pat     = 4'b1010;
    ptyp_pat    = 4'b0110;
    rest        = 1'b1;
    req_valid   = 4'b0;
    req_data    = 32'h0;
    req_par_en  = 4'b0;
    req_par_typ = 4'b0;
    tx_busy     = 1'b0;
    step();
    step();
    check_all_zero("rst");
    rest = 1'b0;
    step();

    // Single request from requester 2, then let it time out.
    req_valid   = 4'b0100;
    req_data    = 32'h00A5_0000;
    req_par_en  = 4'b0100;
    req_par_typ = 4'b0100;
    step();
    check("t1_ready", 32'(req_ready), 32'h4);
    check("t1_nolaunch", 32'(tx_data_valid), 32'h0);
    req_valid = 4'b0;
    step();
    check("t1_ready_off", 32'(req_ready), 32'h0);
    check("t1_launch", 32'(tx_data_valid), 32'h1);
    check("t1_data", 32'(tx_data), 32'hA5);
    check("t1_pen", 32'(tx_par_en), 32'h1);
    check("t1_ptyp", 32'(tx_par_typ), 32'h1);
    check("t1_gid", 32'(grant_id), 32'h2);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("to_early", 32'(timeout_err), 32'h0);
    end
    step();
    check("to_pulse", 32'(timeout_err), 32'h1);
    req_valid  = 4'b0001;
    req_data   = 32'h0000_003C;
    req_par_en = 4'b0000;
    step();
    check("to_once", 32'(timeout_err), 32'h0);
    check("to_next_ready", 32'(req_ready), 32'h1);
    check("to_next_gid", 32'(grant_id), 32'h0);
    check("to_next_data", 32'(tx_data), 32'h3C);
    req_valid = 4'b0;
    step();
    check("t2_launch", 32'(tx_data_valid), 32'h1);
    tx_busy = 1'b1;
    repeat (3) step();
    tx_busy = 1'b0;
    step();

    // Busy blocking in IDLE.
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000_005A;
    for (int i = 0; i < 3; i++) begin
      step();
      check("blk_noready", 32'(req_ready), 32'h0);
    end
    tx_busy = 1'b0;
    step();
    check("blk_ready", 32'(req_ready), 32'h1);
    req_valid = 4'b0;
    step();
    check("blk_launch", 32'(tx_data_valid), 32'h1);
    check("blk_data", 32'(tx_data), 32'h5A);
    tx_busy = 1'b1;
    step();
    step();

    // Asynchronous reset while in WAIT_DONE.
    rest = 1'b1;
    #1;
    check_all_zero("mid");
    step();
    rest      = 1'b0;
    tx_busy   = 1'b0;
    req_data  = {fdata[3], fdata[2], fdata[1], fdata[0]};
    req_par_en  = pen_pat;
    req_par_typ = ptyp_pat;
    req_valid = 4'b1001;
    frame(0);

`ifndef UART_ARB_PRIO0_EN
    req_valid = 4'b1111;
    frame(1);
    frame(2);
    frame(3);
    frame(0);
    frame(1);
`else
    req_valid = 4'b1011;
    frame(0);
    frame(0);
    frame(0);
    req_valid = 4'b1010;
    frame(1);
    frame(3);
    frame(1);
    frame(3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
